// File: rtl/disk_track_cache.sv
// Whole-track buffers for several Disk II drives behind a single MiST SD block channel.
// Dirty tracks are written back before the replacement track is loaded; drives are served round-robin.
module disk_track_cache #(
    parameter int DRIVES     = 2,
    parameter int SECTORS    = 13,
    parameter int TRACK_BITS = 6,
    parameter int ADDR_BITS  = 13,
    localparam int DW        = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [31:0]                  sd_lba,
    output logic                         sd_rd,
    output logic                         sd_wr,
    output logic [DW-1:0]                sd_drive,
    input  logic                         sd_ack,
    input  logic [8:0]                   sd_buff_addr,
    input  logic [7:0]                   sd_buff_dout,
    output logic [7:0]                   sd_buff_din,
    input  logic                         sd_buff_wr,
    input  logic [DRIVES-1:0]            img_mounted,
    input  logic [DRIVES-1:0]            img_present,
    input  logic [DRIVES*TRACK_BITS-1:0] track,
    input  logic [DRIVES-1:0]            save_track,
    input  logic [DW-1:0]                ram_drive,
    input  logic [ADDR_BITS-1:0]         ram_addr,
    input  logic [7:0]                   ram_di,
    input  logic                         ram_we,
    output logic [7:0]                   ram_do,
    output logic [DRIVES-1:0]            busy,
    output logic [DRIVES-1:0]            dirty
);
    localparam int TRACK_BYTES = SECTORS * 512;
    localparam int RAM_BYTES   = DRIVES * TRACK_BYTES;
    localparam int AW          = $clog2(RAM_BYTES);
    localparam int SW          = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam logic [TRACK_BITS-1:0] NO_TRACK = '1;
    localparam logic [1:0] S_IDLE = 2'd0, S_WRITE = 2'd1, S_READ = 2'd2;

    logic [7:0]                         ram [RAM_BYTES];
    logic [1:0]                         state;
    logic [DW-1:0]                      cur_drive, last_served, pick;
    logic [SW-1:0]                      sector;
    logic                               ack_d, pick_vld, start, disk_we;
    logic [DRIVES-1:0]                  ready, save_pend, ld, wb, wb_ok, need;
    logic [DRIVES-1:0][TRACK_BITS-1:0]  cur_track, req_track;
    logic [AW-1:0]                      sd_addr, disk_addr;

    assign req_track = track;
    assign sd_drive  = cur_drive;

    for (genvar d = 0; d < DRIVES; d++) begin : g_need
        assign ld[d]    = req_track[d] != cur_track[d];
        assign wb_ok[d] = dirty[d] && (cur_track[d] != NO_TRACK);
        assign wb[d]    = wb_ok[d] && (save_pend[d] || ld[d]);
        assign need[d]  = ready[d] && (wb[d] || ld[d]);
    end

    // Descending loop so the drive closest after last_served is assigned last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = DRIVES; i >= 1; i--) begin
            if (need[(int'(last_served) + i) % DRIVES]) begin
                pick_vld = 1'b1;
                pick     = DW'((int'(last_served) + i) % DRIVES);
            end
        end
    end

    // A new job never starts while the host still holds ack from an aborted transfer.
    assign start   = (state == S_IDLE) && pick_vld && !img_mounted[pick] && !sd_ack;
    assign disk_we = ram_we && (int'(ram_drive) < DRIVES) && (int'(ram_addr) < TRACK_BYTES)
                     && !busy[ram_drive];

    function automatic logic [31:0] lba_of(input logic [TRACK_BITS-1:0] t, input logic [SW-1:0] s);
        return 32'(t) * 32'(SECTORS) + 32'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cur_drive   <= '0;
            last_served <= DW'(DRIVES - 1);
            sector      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            sd_lba      <= '0;
            ack_d       <= 1'b0;
            ready       <= '0;
            save_pend   <= '0;
            dirty       <= '0;
            busy        <= '0;
            cur_track   <= {DRIVES{NO_TRACK}};
        end else begin
            ack_d <= sd_ack;
            if (sd_ack) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
            end
            if (disk_we)
                dirty[ram_drive] <= 1'b1;
            for (int d = 0; d < DRIVES; d++)
                if (state == S_IDLE && save_pend[d] && !wb_ok[d])
                    save_pend[d] <= 1'b0;

            case (state)
                S_IDLE: if (start) begin
                    cur_drive       <= pick;
                    busy[pick]      <= 1'b1;
                    sector          <= '0;
                    dirty[pick]     <= 1'b0;
                    save_pend[pick] <= 1'b0;
                    if (wb[pick]) begin
                        state  <= S_WRITE;
                        sd_wr  <= 1'b1;
                        sd_lba <= lba_of(cur_track[pick], '0);
                    end else begin
                        state           <= S_READ;
                        cur_track[pick] <= req_track[pick];
                        sd_rd           <= 1'b1;
                        sd_lba          <= lba_of(req_track[pick], '0);
                    end
                end
                S_WRITE, S_READ: if (ack_d && !sd_ack) begin
                    if (sector != SW'(SECTORS - 1)) begin
                        sector <= sector + 1'b1;
                        sd_lba <= lba_of(cur_track[cur_drive], sector + 1'b1);
                        if (state == S_WRITE) sd_wr <= 1'b1;
                        else                  sd_rd <= 1'b1;
                    end else if (state == S_WRITE && ld[cur_drive]) begin
                        state                <= S_READ;
                        sector               <= '0;
                        cur_track[cur_drive] <= req_track[cur_drive];
                        sd_rd                <= 1'b1;
                        sd_lba               <= lba_of(req_track[cur_drive], '0);
                    end else begin
                        state            <= S_IDLE;
                        busy[cur_drive]  <= 1'b0;
                        last_served      <= cur_drive;
                    end
                end
                default: state <= S_IDLE;
            endcase

            for (int d = 0; d < DRIVES; d++)
                if (save_track[d]) save_pend[d] <= 1'b1;

            // Media change discards the buffer and aborts any transfer for that drive.
            for (int d = 0; d < DRIVES; d++) begin
                if (img_mounted[d]) begin
                    ready[d]     <= img_present[d];
                    cur_track[d] <= NO_TRACK;
                    dirty[d]     <= 1'b0;
                    save_pend[d] <= 1'b0;
                    if (state != S_IDLE && int'(cur_drive) == d) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        busy[d] <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            end
        end
    end

    assign sd_addr   = AW'(int'(cur_drive) * TRACK_BYTES + int'(sector) * 512 + int'(sd_buff_addr));
    assign disk_addr = AW'(int'(ram_drive) * TRACK_BYTES + int'(ram_addr));

    always_ff @(posedge clk) begin
        if (sd_buff_wr && state == S_READ)
            ram[sd_addr] <= sd_buff_dout;
        sd_buff_din <= ram[sd_addr];
        if (disk_we)
            ram[disk_addr] <= ram_di;
        ram_do <= ram[disk_addr];
    end
endmodule
